// File: rtl/benes_pkg.sv
`default_nettype none
// ============================================================================
// benes_pkg : shared constants, types and helpers for the Benes config path
// Revision  : 1.0
// ============================================================================
package benes_pkg;

  localparam int NUM_STAGES   = 7;
  localparam int SW_PER_STAGE = 8;
  localparam int STG_W        = $clog2(NUM_STAGES);

  localparam logic [STG_W-1:0] LAST_STAGE  = STG_W'(NUM_STAGES - 1);
  localparam logic [STG_W:0]   STAGE_LIMIT = (STG_W + 1)'(NUM_STAGES);

  typedef logic [SW_PER_STAGE-1:0] stage_set_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } cfg_state_t;

  function automatic logic stage_in_range(input logic [STG_W-1:0] idx);
    return ({1'b0, idx} < STAGE_LIMIT);
  endfunction

  function automatic logic [NUM_STAGES-1:0] stage_onehot(input logic [STG_W-1:0] idx);
    return NUM_STAGES'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/benes_cfg_ctrl_if.sv
`default_nettype none
// ============================================================================
// benes_cfg_ctrl_if : host write/commit handshake for the Benes config sequencer
// Revision          : 1.0
// ============================================================================
interface benes_cfg_ctrl_if;
  import benes_pkg::*;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [STG_W-1:0] cfg_stage;
  stage_set_t       cfg_data;
  logic             commit_valid;
  logic             commit_ready;
  logic             apply_busy;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_stage, cfg_data, commit_valid,
    input  cfg_ready, commit_ready, apply_busy, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_stage, cfg_data, commit_valid,
    output cfg_ready, commit_ready, apply_busy, cfg_err
  );

endinterface
`default_nettype wire

// File: rtl/benes_cfg_shadow.sv
`default_nettype none
// ============================================================================
// benes_cfg_shadow : shadow bank of stage settings plus written-stage mask
// Revision         : 1.0
// ============================================================================
module benes_cfg_shadow
  import benes_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             wr_en,
  input  wire logic [STG_W-1:0] wr_stage,
  input  wire stage_set_t       wr_data,
  input  wire logic             clear,
  output stage_set_t            shadow [NUM_STAGES],
  output logic                  complete
);

  logic [NUM_STAGES-1:0] r_wmask;
  logic [NUM_STAGES-1:0] w_wr_bit;

  assign w_wr_bit = wr_en ? stage_onehot(wr_stage) : '0;
  // A write in the same cycle as a commit counts toward completeness.
  assign complete = &(r_wmask | w_wr_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        shadow[i] <= '0;
      end
      r_wmask <= '0;
    end else begin
      if (wr_en) begin
        shadow[wr_stage] <= wr_data;
      end
      if (clear) begin
        r_wmask <= '0;
      end else begin
        r_wmask <= r_wmask | w_wr_bit;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/benes_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// benes_cfg_ctrl : stages shadow settings into the active bank one stage/clock
// Option         : BENES_CFG_READBACK_EN adds rd_stage/rd_data readback
// Revision       : 1.0
// ============================================================================
module benes_cfg_ctrl
  import benes_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst_n,
  benes_cfg_ctrl_if.slave       cfg,
  output logic [NUM_STAGES-1:0] stage_update,
  output stage_set_t            switch_set [NUM_STAGES]
`ifdef BENES_CFG_READBACK_EN
  ,
  input  wire logic [STG_W-1:0] rd_stage,
  output stage_set_t            rd_data
`endif
);

  cfg_state_t       r_state, w_next_state;
  logic [STG_W-1:0] r_cnt, w_next_cnt;
  logic             r_err;
  logic             w_idle, w_wr_acc, w_wr_ok, w_cm_acc;
  logic             w_complete, w_last, w_clear, w_err;
  stage_set_t       w_shadow [NUM_STAGES];

  assign w_idle   = (r_state == IDLE);
  assign w_wr_acc = cfg.cfg_valid && w_idle;
  assign w_wr_ok  = w_wr_acc && stage_in_range(cfg.cfg_stage);
  assign w_cm_acc = cfg.commit_valid && w_idle;
  assign w_last   = (r_cnt == LAST_STAGE);
  assign w_clear  = !w_idle && w_last;
  // Rejected write and rejected commit in one cycle merge into one pulse.
  assign w_err    = (w_wr_acc && !w_wr_ok) || (w_cm_acc && !w_complete);

  assign cfg.cfg_ready    = w_idle;
  assign cfg.commit_ready = w_idle;
  assign cfg.apply_busy   = !w_idle;
  assign cfg.cfg_err      = r_err;

  benes_cfg_shadow u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (w_wr_ok),
    .wr_stage (cfg.cfg_stage),
    .wr_data  (cfg.cfg_data),
    .clear    (w_clear),
    .shadow   (w_shadow),
    .complete (w_complete)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_cm_acc && w_complete) begin
          w_next_state = APPLY;
          w_next_cnt   = '0;
        end
      end
      APPLY: begin
        w_next_cnt = r_cnt + 1'b1;
        if (w_last) begin
          w_next_state = IDLE;
          w_next_cnt   = '0;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err        <= 1'b0;
      stage_update <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        switch_set[i] <= '0;
      end
    end else begin
      r_err        <= w_err;
      stage_update <= w_idle ? '0 : stage_onehot(r_cnt);
      if (!w_idle) begin
        switch_set[r_cnt] <= w_shadow[r_cnt];
      end
    end
  end

`ifdef BENES_CFG_READBACK_EN
  assign rd_data = stage_in_range(rd_stage) ? switch_set[rd_stage] : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_benes_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// tb_benes_cfg_ctrl : directed self-checking bench for benes_cfg_ctrl
// Revision          : 1.0
// ============================================================================
module tb_benes_cfg_ctrl;
  import benes_pkg::*;

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_STAGES-1:0] stage_update;
  stage_set_t            switch_set [NUM_STAGES];
  int                    n_tests = 0;
  int                    n_fail  = 0;

  benes_cfg_ctrl_if bus();

`ifdef BENES_CFG_READBACK_EN
  logic [STG_W-1:0] rd_stage = '0;
  stage_set_t       rd_data;
`endif

  benes_cfg_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg          (bus),
    .stage_update (stage_update),
    .switch_set   (switch_set)
`ifdef BENES_CFG_READBACK_EN
    ,
    .rd_stage     (rd_stage),
    .rd_data      (rd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sw_pack();
    logic [63:0] p;
    p = '0;
    for (int k = 0; k < NUM_STAGES; k++) p[k*8 +: 8] = switch_set[k];
    return p;
  endfunction

  function automatic logic [63:0] ramp(input int base, input int n);
    logic [63:0] p;
    p = '0;
    for (int k = 0; k < n; k++) p[k*8 +: 8] = 8'(base + k);
    return p;
  endfunction

  // All drive tasks start and end on a falling edge.
  task automatic wr(input int s, input int d);
    bus.cfg_valid = 1'b1;
    bus.cfg_stage = STG_W'(s);
    bus.cfg_data  = 8'(d);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wr_ramp(input int base, input int n);
    for (int k = 0; k < n; k++) wr(k, base + k);
  endtask

  task automatic commit();
    bus.commit_valid = 1'b1;
    @(negedge clk);
    bus.commit_valid = 1'b0;
  endtask

  initial begin
    bus.cfg_valid    = 1'b0;
    bus.cfg_stage    = '0;
    bus.cfg_data     = '0;
    bus.commit_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_ready",  {30'd0, bus.cfg_ready, bus.commit_ready}, 64'h3);
    check("rst_busy",   {63'd0, bus.apply_busy}, 64'h0);
    check("rst_err",    {63'd0, bus.cfg_err}, 64'h0);
    check("rst_update", {57'd0, stage_update}, 64'h0);
    check("rst_sw",     sw_pack(), 64'h0);

    // Walking-one pattern: stage k gets 1<<k
    for (int k = 0; k < NUM_STAGES; k++) wr(k, 1 << k);
    commit();
    check("t1_busy0",   {63'd0, bus.apply_busy}, 64'h1);
    check("t1_upd0",    {57'd0, stage_update}, 64'h0);
    for (int k = 0; k < NUM_STAGES; k++) begin
      @(negedge clk);
      check($sformatf("t1_upd%0d", k), {57'd0, stage_update}, 64'(1) << k);
      check($sformatf("t1_sw%0d", k),  {56'd0, switch_set[k]}, 64'(1) << k);
      check($sformatf("t1_busy%0d", k), {63'd0, bus.apply_busy}, (k < NUM_STAGES-1) ? 64'h1 : 64'h0);
    end
    @(negedge clk);
    check("t1_upd_end", {57'd0, stage_update}, 64'h0);
    check("t1_sw_all",  sw_pack(), 64'h0040201008040201);

    // Incomplete commit is rejected, then completing the bank works
    wr_ramp(8'hA0, 6);
    commit();
    check("t2_err",     {63'd0, bus.cfg_err}, 64'h1);
    check("t2_busy",    {63'd0, bus.apply_busy}, 64'h0);
    check("t2_sw_keep", sw_pack(), 64'h0040201008040201);
    @(negedge clk);
    check("t2_err_off", {63'd0, bus.cfg_err}, 64'h0);
    wr(6, 8'hA6);
    commit();
    check("t2_busy2",   {63'd0, bus.apply_busy}, 64'h1);
    repeat (NUM_STAGES) @(negedge clk);
    check("t2_sw",      sw_pack(), ramp(8'hA0, 7));
    check("t2_idle",    {63'd0, bus.apply_busy}, 64'h0);

    // Final stage written in the same cycle as commit
    wr_ramp(8'h10, 6);
    bus.cfg_valid = 1'b1;
    bus.cfg_stage = STG_W'(6);
    bus.cfg_data  = 8'hFF;
    commit();
    bus.cfg_valid = 1'b0;
    check("t3_busy",    {63'd0, bus.apply_busy}, 64'h1);
    check("t3_err",     {63'd0, bus.cfg_err}, 64'h0);
    repeat (NUM_STAGES) @(negedge clk);
    check("t3_sw6",     {56'd0, switch_set[6]}, 64'hFF);
    check("t3_sw",      sw_pack(), ramp(8'h10, 6) | (64'hFF << 48));

    // Out-of-range stage index
    wr_ramp(8'h30, 7);
    wr(7, 8'h99);
    check("t4_err",     {63'd0, bus.cfg_err}, 64'h1);
    @(negedge clk);
    check("t4_err_off", {63'd0, bus.cfg_err}, 64'h0);
    commit();
    check("t4_busy",    {63'd0, bus.apply_busy}, 64'h1);
    repeat (NUM_STAGES) @(negedge clk);
    check("t4_sw",      sw_pack(), ramp(8'h30, 7));

    // Requests held during APPLY are not accepted
    wr_ramp(8'h50, 7);
    commit();
    bus.cfg_valid    = 1'b1;
    bus.cfg_stage    = '0;
    bus.cfg_data     = 8'hEE;
    bus.commit_valid = 1'b1;
    for (int i = 0; i < NUM_STAGES; i++) begin
      check($sformatf("t5_ready%0d", i), {62'd0, bus.cfg_ready, bus.commit_ready}, 64'h0);
      @(negedge clk);
    end
    check("t5_ready_idle", {62'd0, bus.cfg_ready, bus.commit_ready}, 64'h3);
    check("t5_err",     {63'd0, bus.cfg_err}, 64'h0);
    bus.cfg_valid    = 1'b0;
    bus.commit_valid = 1'b0;
    check("t5_sw",      sw_pack(), ramp(8'h50, 7));
    commit();
    check("t5_mask_clr", {63'd0, bus.cfg_err}, 64'h1);

    // Reset in the middle of APPLY
    @(negedge clk);
    wr_ramp(8'h70, 7);
    commit();
    repeat (3) @(negedge clk);
    check("t6_partial", sw_pack(), ramp(8'h70, 3) | (ramp(8'h50, 7) & ~64'hFFFFFF));
    rst_n = 1'b0;
    #1;
    check("t6_rst_sw",   sw_pack(), 64'h0);
    check("t6_rst_busy", {63'd0, bus.apply_busy}, 64'h0);
    check("t6_rst_upd",  {57'd0, stage_update}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    commit();
    check("t6_err",      {63'd0, bus.cfg_err}, 64'h1);
    check("t6_busy",     {63'd0, bus.apply_busy}, 64'h0);
    check("t6_sw",       sw_pack(), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
